// File: rtl/dma_cmd_queue_if.sv
// Processor-side and dma-side signals of the DMA command queue, bundled.
// The master modport is the processor/dma environment; slave is the queue.
interface dma_cmd_queue_if #(
    parameter int DEPTH = 4
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic          push;
    logic [31:0]   push_desc;
    logic [1:0]    push_cmd;
    logic          push_ready;
    logic [LW-1:0] level;
    logic          dreq;
    logic [1:0]    cmd;
    logic [31:0]   desc_out;
    logic          desc_oe;
    logic          ddone;
    logic          busy;
    logic          done_pulse;
    logic [7:0]    completed;
    logic          timeout_err;
    logic          push_err;

    modport master (
        output push, push_desc, push_cmd, ddone,
        input  push_ready, level, dreq, cmd, desc_out, desc_oe,
               busy, done_pulse, completed, timeout_err, push_err
    );

    modport slave (
        input  push, push_desc, push_cmd, ddone,
        output push_ready, level, dreq, cmd, desc_out, desc_oe,
               busy, done_pulse, completed, timeout_err, push_err
    );
endinterface

// File: rtl/dma_cmd_queue.sv
// Descriptor FIFO plus issue sequencer feeding the dma engine one transfer
// at a time over the dreq / cmd / databus handshake, with timeout abort.
module dma_cmd_queue #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic           clk,
    input  logic           reset_n,
    dma_cmd_queue_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam int CW = $clog2(TIMEOUT);
    localparam logic [1:0] CMD_RSVD = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_REQ,
        S_WAIT,
        S_RELEASE
    } state_t;

    // Each FIFO entry holds {cmd, descriptor}.
    logic [33:0]   r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [LW-1:0] r_level;
    logic          r_push_ready;

    state_t        r_state;
    state_t        w_state_next;
    logic [CW-1:0] r_wait_cnt;

    logic          r_dreq;
    logic          r_desc_oe;
    logic          r_busy;
    logic          r_done_pulse;
    logic          r_timeout_err;
    logic          r_push_err;
    logic [31:0]   r_desc_out;
    logic [1:0]    r_cmd;
    logic [7:0]    r_completed;

    logic          w_push_ok;
    logic          w_push_bad;
    logic          w_pop;
    logic          w_success;
    logic          w_abort;
    logic          w_dreq_next;
    logic          w_desc_oe_next;
    logic [LW-1:0] w_level_next;

    assign w_push_ok  = bus.push && r_push_ready &&
                        (bus.push_desc[31:26] != 6'd0) &&
                        (bus.push_cmd != CMD_RSVD);
    assign w_push_bad = bus.push && !w_push_ok;

    // Occupancy after this edge; a simultaneous push and pop cancel out.
    always_comb begin
        w_level_next = r_level;
        if (w_push_ok && !w_pop) begin
            w_level_next = r_level + LW'(1);
        end else if (!w_push_ok && w_pop) begin
            w_level_next = r_level - LW'(1);
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is 2^PW.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_level      <= '0;
            r_push_ready <= 1'b1;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            r_level      <= w_level_next;
            r_push_ready <= (w_level_next != LW'(DEPTH));
        end
    end

    // FIFO storage; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= {bus.push_cmd, bus.push_desc};
        end
    end

    // Issue sequencer state register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state, pop/finish decisions and next values of the bus strobes.
    // WAIT lasts at most TIMEOUT-1 cycles so dreq (REQ + WAIT) is high for
    // exactly TIMEOUT cycles on an abort; ddone wins over the timeout.
    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_success    = 1'b0;
        w_abort      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_level != '0) begin
                    w_pop        = 1'b1;
                    w_state_next = S_SETUP;
                end
            end
            S_SETUP:   w_state_next = S_REQ;
            S_REQ:     w_state_next = S_WAIT;
            S_WAIT: begin
                if (bus.ddone) begin
                    w_success    = 1'b1;
                    w_state_next = S_RELEASE;
                end else if (r_wait_cnt == CW'(TIMEOUT - 2)) begin
                    w_abort      = 1'b1;
                    w_state_next = S_RELEASE;
                end
            end
            S_RELEASE: w_state_next = S_IDLE;
            default:   w_state_next = S_IDLE;
        endcase
        w_dreq_next    = (w_state_next == S_REQ)   || (w_state_next == S_WAIT);
        w_desc_oe_next = (w_state_next == S_SETUP) || (w_state_next == S_REQ);
    end

    // Registered outputs, issue registers, counters and sticky error flags.
    // busy follows the state one cycle late so it stays up through RELEASE.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_dreq        <= 1'b0;
            r_desc_oe     <= 1'b0;
            r_busy        <= 1'b0;
            r_done_pulse  <= 1'b0;
            r_completed   <= '0;
            r_timeout_err <= 1'b0;
            r_push_err    <= 1'b0;
            r_desc_out    <= '0;
            r_cmd         <= '0;
            r_wait_cnt    <= '0;
        end else begin
            r_dreq       <= w_dreq_next;
            r_desc_oe    <= w_desc_oe_next;
            r_busy       <= (r_state != S_IDLE);
            r_done_pulse <= w_success;
            if (w_success) begin
                r_completed <= r_completed + 8'd1;
            end
            if (w_abort) begin
                r_timeout_err <= 1'b1;
            end
            if (w_push_bad) begin
                r_push_err <= 1'b1;
            end
            if (w_pop) begin
                {r_cmd, r_desc_out} <= r_mem[r_rd_ptr];
            end
            if (r_state == S_WAIT) begin
                r_wait_cnt <= r_wait_cnt + CW'(1);
            end else begin
                r_wait_cnt <= '0;
            end
        end
    end

    assign bus.push_ready  = r_push_ready;
    assign bus.level       = r_level;
    assign bus.dreq        = r_dreq;
    assign bus.cmd         = r_cmd;
    assign bus.desc_out    = r_desc_out;
    assign bus.desc_oe     = r_desc_oe;
    assign bus.busy        = r_busy;
    assign bus.done_pulse  = r_done_pulse;
    assign bus.completed   = r_completed;
    assign bus.timeout_err = r_timeout_err;
    assign bus.push_err    = r_push_err;
endmodule

// File: tb/tb_dma_cmd_queue.sv
// Bench for dma_cmd_queue: directed scenarios with literal expectations plus
// an event-time model compared against every output on every cycle.
module tb_dma_cmd_queue;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 8;
    localparam int BIG     = 1 << 30;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    int   checks  = 0;
    int   errors  = 0;

    dma_cmd_queue_if #(.DEPTH(DEPTH)) bus ();

    dma_cmd_queue #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endfunction

    // Model: a queue of accepted descriptors and, for the transfer in flight,
    // the edge it was popped (m_p) and the edge it finished (m_e).
    int          cyc = 0;
    bit          started = 1'b0;
    logic [33:0] mq[$];
    logic [33:0] m_head;
    int          m_p = -100;
    int          m_e = -100;
    bit          m_ended = 1'b1;
    bit          m_success = 1'b0;
    bit          m_pop_now;
    logic [31:0] m_desc = '0;
    logic [1:0]  m_cmd = '0;
    logic [7:0]  m_completed = '0;
    bit          m_terr = 1'b0;
    bit          m_perr = 1'b0;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            started = 1'b1;
            if (!reset_n) begin
                mq.delete();
                m_p = -100; m_e = -100; m_ended = 1'b1; m_success = 1'b0;
                m_desc = '0; m_cmd = '0; m_completed = '0;
                m_terr = 1'b0; m_perr = 1'b0;
            end else begin
                if (!m_ended) begin
                    if (bus.ddone && cyc >= m_p + 3) begin
                        m_ended = 1'b1; m_success = 1'b1; m_e = cyc;
                        m_completed = m_completed + 8'd1;
                    end else if (cyc == m_p + TIMEOUT + 1) begin
                        m_ended = 1'b1; m_success = 1'b0; m_e = cyc;
                        m_terr = 1'b1;
                    end
                end
                m_pop_now = m_ended && (cyc >= m_e + 2) && (mq.size() > 0);
                if (bus.push) begin
                    if (mq.size() < DEPTH && bus.push_desc[31:26] != 6'd0 && bus.push_cmd != 2'b11)
                        mq.push_back({bus.push_cmd, bus.push_desc});
                    else
                        m_perr = 1'b1;
                end
                if (m_pop_now) begin
                    m_head = mq.pop_front();
                    {m_cmd, m_desc} = m_head;
                    m_p = cyc; m_e = BIG; m_ended = 1'b0; m_success = 1'b0;
                end
            end
        end
    end

    // Compare every output against the model, mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (started) begin
                check("level",       32'(bus.level),       32'(mq.size()));
                check("push_ready",  32'(bus.push_ready),  32'(mq.size() != DEPTH));
                check("desc_oe",     32'(bus.desc_oe),     32'(cyc == m_p || cyc == m_p + 1));
                check("dreq",        32'(bus.dreq),        32'(cyc >= m_p + 1 && cyc < m_e));
                check("busy",        32'(bus.busy),        32'(cyc >= m_p + 1 && cyc <= m_e + 1));
                check("done_pulse",  32'(bus.done_pulse),  32'(m_success && cyc == m_e));
                check("completed",   32'(bus.completed),   32'(m_completed));
                check("timeout_err", 32'(bus.timeout_err), 32'(m_terr));
                check("push_err",    32'(bus.push_err),    32'(m_perr));
                check("desc_out",    bus.desc_out,         m_desc);
                check("cmd",         32'(bus.cmd),         32'(m_cmd));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [31:0] d, input logic [1:0] c);
        bus.push      = 1'b1;
        bus.push_desc = d;
        bus.push_cmd  = c;
        step();
        bus.push = 1'b0;
        $display("push desc=%h cmd=%0d level=%0d push_err=%0b", d, c, bus.level, bus.push_err);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
    endtask

    // Steps until dreq is seen high; returns how many low cycles were stepped.
    task automatic wait_rise(output int low);
        low = 0;
        while (bus.dreq !== 1'b1 && low < 300) begin
            step();
            low++;
        end
        if (bus.dreq !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL dreq_rise actual=no_rise required=rise t=%0t", $time);
        end
    endtask

    // Called right after dreq is first seen high: ddone lands in WAIT.
    task automatic complete_current();
        step();
        bus.ddone = 1'b1;
        step();
        bus.ddone = 1'b0;
        $display("complete desc=%h cmd=%0d completed=%0d", bus.desc_out, bus.cmd, bus.completed);
    endtask

    logic [31:0] exp_desc [5];
    logic [1:0]  exp_cmd  [5];

    initial begin
        int low;
        int hi;
        bus.push = 1'b0; bus.push_desc = '0; bus.push_cmd = '0; bus.ddone = 1'b0;
        exp_desc[0] = 32'h0400_4046; exp_cmd[0] = 2'd0;
        exp_desc[1] = 32'h0800_2001; exp_cmd[1] = 2'd1;
        exp_desc[2] = 32'h0C00_0010; exp_cmd[2] = 2'd2;
        exp_desc[3] = 32'h1000_0020; exp_cmd[3] = 2'd0;
        exp_desc[4] = 32'h1400_0030; exp_cmd[4] = 2'd1;
        step();
        step();
        reset_n = 1'b1;

        // Reset state
        check("rst_level",      32'(bus.level),      32'd0);
        check("rst_push_ready", 32'(bus.push_ready), 32'd1);
        check("rst_dreq",       32'(bus.dreq),       32'd0);
        check("rst_desc_out",   bus.desc_out,        32'd0);

        // Single move: exact edge timing
        push_one(32'h0400_4046, 2'b00);
        check("t1_level_n",    32'(bus.level),   32'd1);
        check("t1_oe_n",       32'(bus.desc_oe), 32'd0);
        step();
        check("t1_oe_n1",      32'(bus.desc_oe), 32'd1);
        check("t1_dreq_n1",    32'(bus.dreq),    32'd0);
        check("t1_desc_out",   bus.desc_out,     32'h0400_4046);
        step();
        check("t1_oe_n2",      32'(bus.desc_oe), 32'd1);
        check("t1_dreq_n2",    32'(bus.dreq),    32'd1);
        step();
        check("t1_oe_n3",      32'(bus.desc_oe), 32'd0);
        check("t1_dreq_n3",    32'(bus.dreq),    32'd1);
        bus.ddone = 1'b1;
        step();
        bus.ddone = 1'b0;
        check("t1_dreq_m",     32'(bus.dreq),       32'd0);
        check("t1_pulse_m",    32'(bus.done_pulse), 32'd1);
        check("t1_completed",  32'(bus.completed),  32'd1);
        check("t1_busy_m",     32'(bus.busy),       32'd1);
        step();
        check("t1_pulse_m1",   32'(bus.done_pulse), 32'd0);
        check("t1_busy_m1",    32'(bus.busy),       32'd1);
        step();
        check("t1_busy_m2",    32'(bus.busy),       32'd0);
        $display("complete desc=%h cmd=%0d completed=%0d", bus.desc_out, bus.cmd, bus.completed);

        // Back-to-back: fill while the first transfer is in flight
        do_reset();
        for (int i = 0; i < 5; i++) push_one(exp_desc[i], exp_cmd[i]);
        check("t2_level_full", 32'(bus.level),      32'd4);
        check("t2_ready_full", 32'(bus.push_ready), 32'd0);
        push_one(32'h1800_0040, 2'b10);
        check("t2_push_err",   32'(bus.push_err),   32'd1);
        check("t2_level_kept", 32'(bus.level),      32'd4);
        check("t2_desc0",      bus.desc_out,        exp_desc[0]);
        complete_current();
        for (int i = 1; i < 5; i++) begin
            wait_rise(low);
            check("t2_low_gap", 32'(low),     32'd3);
            check("t2_order",   bus.desc_out, exp_desc[i]);
            check("t2_cmd",     32'(bus.cmd), 32'(exp_cmd[i]));
            complete_current();
        end
        step();
        step();
        check("t2_completed", 32'(bus.completed), 32'd5);
        check("t2_busy",      32'(bus.busy),      32'd0);

        // Timeout: dreq high exactly TIMEOUT cycles, next descriptor still issues
        do_reset();
        push_one(32'h0400_0100, 2'b01);
        push_one(32'h0800_0200, 2'b10);
        wait_rise(low);
        hi = 1;
        while (hi < 200) begin
            step();
            if (bus.dreq !== 1'b1) break;
            hi++;
        end
        check("t3_dreq_high", 32'(hi),               32'(TIMEOUT));
        check("t3_terr",      32'(bus.timeout_err),  32'd1);
        check("t3_no_pulse",  32'(bus.done_pulse),   32'd0);
        check("t3_completed", 32'(bus.completed),    32'd0);
        $display("abort desc=%h timeout_err=%0b", bus.desc_out, bus.timeout_err);
        wait_rise(low);
        check("t3_low_gap",   32'(low),              32'd3);
        check("t3_next_desc", bus.desc_out,          32'h0800_0200);
        complete_current();
        check("t3_completed2", 32'(bus.completed),   32'd1);
        check("t3_terr_stick", 32'(bus.timeout_err), 32'd1);

        // Illegal pushes
        do_reset();
        push_one(32'h0000_1234, 2'b00);
        push_one(32'h0400_0001, 2'b11);
        check("t4_push_err", 32'(bus.push_err), 32'd1);
        check("t4_level",    32'(bus.level),    32'd0);
        repeat (6) step();
        check("t4_no_dreq",  32'(bus.dreq),     32'd0);
        check("t4_busy",     32'(bus.busy),     32'd0);

        // Simultaneous push and pop
        do_reset();
        push_one(32'h0400_0a0a, 2'b00);
        push_one(32'h0800_0b0b, 2'b01);
        check("t5_level_same", 32'(bus.level), 32'd1);
        wait_rise(low);
        check("t5_first",      bus.desc_out,   32'h0400_0a0a);
        complete_current();
        wait_rise(low);
        check("t5_second",     bus.desc_out,   32'h0800_0b0b);
        check("t5_second_cmd", 32'(bus.cmd),   32'd1);
        complete_current();
        step();
        step();
        check("t5_completed",  32'(bus.completed), 32'd2);
        check("t5_level_end",  32'(bus.level),     32'd0);

        // Reset in WAIT with two queued
        do_reset();
        push_one(32'h0000_0001, 2'b00);
        push_one(32'h0400_0001, 2'b00);
        push_one(32'h0800_0002, 2'b01);
        push_one(32'h0C00_0003, 2'b10);
        step();
        check("t6_level_pre", 32'(bus.level),    32'd2);
        check("t6_dreq_pre",  32'(bus.dreq),     32'd1);
        check("t6_perr_pre",  32'(bus.push_err), 32'd1);
        do_reset();
        $display("reset mid-wait level=%0d dreq=%0b", bus.level, bus.dreq);
        check("t6_dreq",      32'(bus.dreq),        32'd0);
        check("t6_level",     32'(bus.level),       32'd0);
        check("t6_busy",      32'(bus.busy),        32'd0);
        check("t6_completed", 32'(bus.completed),   32'd0);
        check("t6_perr",      32'(bus.push_err),    32'd0);
        check("t6_terr",      32'(bus.timeout_err), 32'd0);
        check("t6_ready",     32'(bus.push_ready),  32'd1);
        bus.ddone = 1'b1;
        step();
        bus.ddone = 1'b0;
        check("t6_stray_pulse", 32'(bus.done_pulse), 32'd0);
        repeat (4) step();
        check("t6_stray_cnt",   32'(bus.completed),  32'd0);
        check("t6_stray_dreq",  32'(bus.dreq),       32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished t=%0t", $time);
        $fatal(1, "watchdog");
    end
endmodule
